ldtu_word_serializer: RTL



---
 rtl/ldtu_word_serializer.sv | 86 ++++++++
 1 files changed

// File: rtl/ldtu_word_serializer.sv
// Word-to-slice serializer for the LiTE-DTU output lane: one holding register in
// front of a shift register that emits a continuous stream of data, idle or training words.
module ldtu_word_serializer #(
   parameter int                  Nbits_32   = 32,
   parameter int                  SER_BITS   = 4,
   parameter logic [Nbits_32-1:0] IDLE_WORD  = 32'h5A5A_5A5A,
   parameter logic [Nbits_32-1:0] TRAIN_WORD = 32'hEAAA_AAAA
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [Nbits_32-1:0] DATA32_IN,
   input  logic                DATA_VALID,
   output logic                DATA_READY,
   input  logic                TRAINING,
   output logic [SER_BITS-1:0] SER_OUT,
   output logic                WORD_START,
   output logic [1:0]          WORD_KIND,
   output logic [15:0]         UNDERRUN_CNT
);

   localparam int NSLICE = Nbits_32 / SER_BITS;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      KIND_IDLE  = 2'b00,
      KIND_DATA  = 2'b01,
      KIND_TRAIN = 2'b10
   } kind_t;

   logic [Nbits_32-1:0] hold;
   logic                hold_full;
   logic [Nbits_32-1:0] shreg;
   logic [CNT_W-1:0]    cnt;
   kind_t               kind;
   logic                started;
   logic                accept;

   assign DATA_READY = ~hold_full;
   assign accept     = DATA_VALID & ~hold_full;
   assign SER_OUT    = shreg[Nbits_32-1 -: SER_BITS];
   assign WORD_START = (cnt == '0) & started;
   assign WORD_KIND  = kind;

   // Counter starts on the last slice so the first edge out of reset loads a word.
   // NOTE: all state here is edge-triggered, so every assignment is non-blocking;
   // blocking assignments would let later statements see same-edge updates.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hold         <= '0;
         hold_full    <= 1'b0;
         shreg        <= '0;
         cnt          <= LAST_SLICE;
         kind         <= KIND_IDLE;
         started      <= 1'b0;
         UNDERRUN_CNT <= '0;
      end else begin
         if (accept) begin
            hold      <= DATA32_IN;
            hold_full <= 1'b1;
         end

         if (cnt == LAST_SLICE) begin
            cnt     <= '0;
            started <= 1'b1;
            // Training overrides data without consuming it; hold stays pending.
            if (TRAINING) begin
               shreg <= TRAIN_WORD;
               kind  <= KIND_TRAIN;
            end else if (hold_full) begin
               shreg     <= hold;
               kind      <= KIND_DATA;
               hold_full <= 1'b0;
            end else begin
               shreg <= IDLE_WORD;
               kind  <= KIND_IDLE;
               if (UNDERRUN_CNT != 16'hFFFF) UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
            end
         end else begin
            shreg <= shreg << SER_BITS;
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

endmodule
